// File: rtl/seg7_count_display.sv
// Samples a glitchy asynchronous 4-bit counter value, debounces it, and drives
// a two-digit multiplexed seven-segment display with blank slots between digits.
module seg7_count_display #(
  parameter int unsigned SCAN_DIV        = 200,
  parameter int unsigned BLANK_CYC       = 4,
  parameter int unsigned STABLE_CYC      = 4,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1,
  parameter bit          DIG_ACTIVE_LOW  = 1'b0,
  parameter bit          LEAD_ZERO_BLANK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic       enable,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_en,
  output logic [3:0] value,
  output logic       value_valid
);

  localparam int unsigned MAX_SLOT = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned TW       = $clog2(MAX_SLOT + 1);
  localparam int unsigned SW       = $clog2(STABLE_CYC + 1);
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]  DIG_OFF  = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic [1:0] {SHOW_ONES, BLANK_A, SHOW_TENS, BLANK_B} state_t;

  logic [3:0]    s1, s2;
  logic [SW-1:0] stable_cnt, stable_next;
  logic          accept;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          slot_last;
  logic          tens;
  logic [3:0]    ones;
  logic [6:0]    seg_raw, seg_n;
  logic [1:0]    dig_raw, dig_n;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'h3F;
      4'd1:    seg_pat = 7'h06;
      4'd2:    seg_pat = 7'h5B;
      4'd3:    seg_pat = 7'h4F;
      4'd4:    seg_pat = 7'h66;
      4'd5:    seg_pat = 7'h6D;
      4'd6:    seg_pat = 7'h7D;
      4'd7:    seg_pat = 7'h07;
      4'd8:    seg_pat = 7'h7F;
      4'd9:    seg_pat = 7'h6F;
      default: seg_pat = 7'h00;
    endcase
  endfunction

  // Stability count includes the sample entering s2 this edge, so acceptance
  // lands 2 + STABLE_CYC edges after a clean input change.
  always_comb begin
    stable_next = stable_cnt;
    if (s1 != s2)
      stable_next = '0;
    else if (stable_cnt != SW'(STABLE_CYC))
      stable_next = stable_cnt + SW'(1);
    accept = (stable_next == SW'(STABLE_CYC)) && (s2 != value);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      stable_cnt  <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      s1          <= count_in;
      s2          <= s1;
      stable_cnt  <= stable_next;
      value_valid <= accept;
      if (accept)
        value <= s2;
    end
  end

  assign tens = (value >= 4'd10);
  assign ones = tens ? value - 4'd10 : value;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW_ONES;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // Scan sequencing and the next display drive for the current slot.
  always_comb begin
    state_n   = state;
    timer_n   = timer + TW'(1);
    seg_raw   = 7'h00;
    dig_raw   = 2'b00;
    slot_last = 1'b0;
    case (state)
      SHOW_ONES: begin
        dig_raw   = 2'b01;
        seg_raw   = seg_pat(ones);
        slot_last = (timer == TW'(SCAN_DIV - 1));
        if (slot_last) state_n = (BLANK_CYC == 0) ? SHOW_TENS : BLANK_A;
      end
      BLANK_A: begin
        slot_last = (BLANK_CYC == 0) || (timer == TW'(BLANK_CYC - 1));
        if (slot_last) state_n = SHOW_TENS;
      end
      SHOW_TENS: begin
        if (!LEAD_ZERO_BLANK || tens) begin
          dig_raw = 2'b10;
          seg_raw = seg_pat({3'b000, tens});
        end
        slot_last = (timer == TW'(SCAN_DIV - 1));
        if (slot_last) state_n = (BLANK_CYC == 0) ? SHOW_ONES : BLANK_B;
      end
      BLANK_B: begin
        slot_last = (BLANK_CYC == 0) || (timer == TW'(BLANK_CYC - 1));
        if (slot_last) state_n = SHOW_ONES;
      end
      default: begin
        slot_last = 1'b1;
        state_n   = SHOW_ONES;
      end
    endcase
    if (slot_last)
      timer_n = '0;
    if (!enable) begin
      state_n = SHOW_ONES;
      timer_n = '0;
      seg_raw = 7'h00;
      dig_raw = 2'b00;
    end
    seg_n = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_n = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg      <= SEG_OFF;
      dp       <= SEG_ACTIVE_LOW;
      digit_en <= DIG_OFF;
    end else begin
      seg      <= seg_n;
      dp       <= SEG_ACTIVE_LOW;
      digit_en <= dig_n;
    end
  end

endmodule

// File: tb/tb_seg7_count_display.sv
// Bench for seg7_count_display: directed scenarios plus random input traffic,
// checked every cycle against an arithmetic model of debounce and scan timing.
module tb_seg7_count_display;

  localparam int unsigned SCAN   = 8;
  localparam int unsigned BLANK  = 2;
  localparam int unsigned STAB   = 4;
  localparam int unsigned PERIOD = 2 * (SCAN + BLANK);
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_en;
  logic [3:0] value;
  logic       value_valid;

  int tests = 0;
  int fails = 0;

  // model state
  int         hist[$];
  int         mv = 0;
  bit         mvalid = 1'b0;
  int         phase = 0;
  logic [6:0] exp_seg;
  logic [1:0] exp_dig;

  // scratch for directed steps
  int seen_ones, seen_tens, pulses, bad, n00, n01, n10, n11, guard, run, hold;
  int rip[4] = '{6, 4, 0, 8};

  seg7_count_display #(
    .SCAN_DIV(SCAN), .BLANK_CYC(BLANK), .STABLE_CYC(STAB),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0), .LEAD_ZERO_BLANK(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .enable(enable),
    .seg(seg), .dp(dp), .digit_en(digit_en), .value(value), .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    bit same;
    @(posedge clk);
    exp_dig = 2'b00;
    exp_seg = 7'h7F;
    if (!reset && enable) begin
      if (phase < int'(SCAN)) begin
        exp_dig = 2'b01;
        exp_seg = ~PAT[mv % 10];
      end else if (phase >= int'(SCAN + BLANK) && phase < int'(2*SCAN + BLANK) && mv >= 10) begin
        exp_dig = 2'b10;
        exp_seg = ~PAT[mv / 10];
      end
    end
    phase = (reset || !enable) ? 0 : (phase + 1) % int'(PERIOD);
    if (reset) begin
      hist.delete();
      mv = 0;
      mvalid = 1'b0;
    end else begin
      mvalid = 1'b0;
      if (hist.size() == int'(STAB + 1)) begin
        same = 1'b1;
        for (int i = 1; i < hist.size(); i++)
          if (hist[i] != hist[0]) same = 1'b0;
        if (same && hist[0] != mv) begin
          mv = hist[0];
          mvalid = 1'b1;
        end
      end
      hist.push_back(int'(count_in));
      if (hist.size() > int'(STAB + 1)) void'(hist.pop_front());
    end
    #1;
    check("value", value, mv);
    check("value_valid", value_valid, mvalid);
    check("digit_en", digit_en, exp_dig);
    check("seg", seg, exp_seg);
    check("dp", dp, 1'b1);
    check("both_digits", digit_en == 2'b11, 1'b0);
  endtask

  initial begin
    // 1: reset, then scan value 0
    repeat (3) tick();
    check("rst_seg", seg, 7'h7F);
    check("rst_dig", digit_en, 2'b00);
    check("rst_val", value, 4'd0);
    reset = 1'b0;
    enable = 1'b1;
    tick();
    check("t1_dig", digit_en, 2'b01);
    check("t1_seg", seg, 7'h40);
    repeat (10) tick();
    check("t1_tens_blank", digit_en, 2'b00);

    // 2: 0 -> 13 latency and patterns
    count_in = 4'd13;
    repeat (5) tick();
    check("t2_pre_val", value, 4'd0);
    check("t2_pre_vv", value_valid, 1'b0);
    tick();
    check("t2_val", value, 4'd13);
    check("t2_vv", value_valid, 1'b1);
    tick();
    check("t2_vv_pulse", value_valid, 1'b0);
    seen_ones = 0;
    seen_tens = 0;
    repeat (PERIOD) begin
      tick();
      if (digit_en == 2'b01 && seg == 7'h30) seen_ones++;
      if (digit_en == 2'b10 && seg == 7'h79) seen_tens++;
    end
    check("t2_ones_slot", seen_ones, SCAN);
    check("t2_tens_slot", seen_tens, SCAN);

    // 3: ripple intermediates are rejected
    count_in = 4'd7;
    repeat (10) tick();
    check("t3_val7", value, 4'd7);
    pulses = 0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      count_in = 4'(rip[i]);
      tick();
      if (value_valid) pulses++;
      if (value != 4'd7 && value != 4'd8) bad++;
    end
    repeat (12) begin
      tick();
      if (value_valid) pulses++;
      if (value != 4'd7 && value != 4'd8) bad++;
    end
    check("t3_pulses", pulses, 1);
    check("t3_no_intermediate", bad, 0);
    check("t3_val8", value, 4'd8);

    // 4: free-running scan slot occupancy over one period
    n00 = 0; n01 = 0; n10 = 0; n11 = 0;
    count_in = 4'd12;
    repeat (8) tick();
    repeat (PERIOD) begin
      tick();
      case (digit_en)
        2'b00: n00++;
        2'b01: n01++;
        2'b10: n10++;
        default: n11++;
      endcase
    end
    check("t4_ones_cycles", n01, SCAN);
    check("t4_tens_cycles", n10, SCAN);
    check("t4_blank_cycles", n00, 2 * BLANK);
    check("t4_both_cycles", n11, 0);

    // 5: disable mid tens slot, re-enable gives a full ones slot
    guard = 0;
    while (digit_en != 2'b10 && guard < int'(2 * PERIOD)) begin
      tick();
      guard++;
    end
    check("t5_found_tens", digit_en, 2'b10);
    repeat (2) tick();
    enable = 1'b0;
    tick();
    check("t5_off_dig", digit_en, 2'b00);
    check("t5_off_seg", seg, 7'h7F);
    repeat (3) tick();
    enable = 1'b1;
    run = 0;
    tick();
    while (digit_en == 2'b01 && run < int'(3 * SCAN)) begin
      run++;
      tick();
    end
    check("t5_full_slot", run, SCAN);

    // 6: reset while showing 15
    count_in = 4'd15;
    repeat (10) tick();
    check("t6_val15", value, 4'd15);
    reset = 1'b1;
    tick();
    check("t6_rst_val", value, 4'd0);
    check("t6_rst_dig", digit_en, 2'b00);
    check("t6_rst_seg", seg, 7'h7F);
    reset = 1'b0;
    repeat (5) tick();
    check("t6_pre_val", value, 4'd0);
    tick();
    check("t6_reaccept", value, 4'd15);
    check("t6_reaccept_vv", value_valid, 1'b1);

    // random traffic: glitch bursts, enable toggles, occasional resets
    for (int it = 0; it < 300; it++) begin
      count_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 40) == 0) reset = 1'b1;
      hold = $urandom_range(1, 8);
      repeat (hold) tick();
      reset = 1'b0;
    end
    enable = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
